// File: rtl/ita_hwpe_bias_stream_packer_pkg.sv
// Shared constants and FSM state type for the bias stream packer.
package ita_package;

   localparam int unsigned BIAS_IN_WIDTH   = 32;
   localparam int unsigned BIAS_OUT_WIDTH  = 768;
   localparam int unsigned BIAS_PACK_RATIO = BIAS_OUT_WIDTH / BIAS_IN_WIDTH;

   typedef enum logic {
      Fill  = 1'b0,
      Drain = 1'b1
   } bias_pack_state_e;

endpackage

// File: rtl/ita_hwpe_bias_stream_packer_if.sv
// Valid/ready stream bundle with data and byte strobes.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/ita_hwpe_bias_stream_packer.sv
// Packs narrow streamer beats LSB-first into wide bias words, with zero-padded flush
// and a per-tile word counter that pulses done_o on the last word of each tile.
module ita_hwpe_bias_stream_packer
   import ita_package::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH  = BIAS_IN_WIDTH,
   parameter int unsigned OUTPUT_DATA_WIDTH = BIAS_OUT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   flush_i,
   input  logic [7:0]             tile_beats_i,
   hwpe_stream_intf_stream.sink   data_i,
   hwpe_stream_intf_stream.source data_o,
   output logic                   done_o
);

   localparam int unsigned IW  = INPUT_DATA_WIDTH;
   localparam int unsigned R   = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH;
   localparam int unsigned SW  = INPUT_DATA_WIDTH / 8;
   localparam int unsigned OSW = OUTPUT_DATA_WIDTH / 8;
   localparam int unsigned CW  = $clog2(R);

   bias_pack_state_e       state_reg, state_next;
   logic [CW-1:0]          lane_cnt_reg, lane_cnt_next;
   logic [OUTPUT_DATA_WIDTH-1:0] data_reg, data_next;
   logic [OSW-1:0]         strb_reg, strb_next;
   logic [7:0]             word_cnt_reg, tile_len_reg;
   logic                   done_reg;

   logic                   fill;
   logic                   in_hs, out_hs;
   logic                   last_lane, flush_go, word_done;
   logic [CW:0]            next_lane;
   logic [7:0]             eff_len;
   logic                   tile_last;

   assign fill      = (state_reg == Fill);
   assign in_hs     = fill && data_i.valid;
   assign out_hs    = !fill && data_o.ready;
   assign next_lane = {1'b0, lane_cnt_reg} + (CW+1)'(in_hs);
   assign last_lane = in_hs && (lane_cnt_reg == CW'(R-1));
   // A flush at lane 0 still closes the word when a beat lands in the same cycle.
   assign flush_go  = fill && flush_i && ((lane_cnt_reg != '0) || in_hs);
   assign word_done = last_lane || flush_go;

   always_comb begin
      lane_cnt_next = lane_cnt_reg;
      if (word_done) begin
         lane_cnt_next = '0;
      end else if (in_hs) begin
         lane_cnt_next = lane_cnt_reg + CW'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < R; gi++) begin : g_lane
         logic lane_wr, lane_pad;
         assign lane_wr  = in_hs && (lane_cnt_reg == CW'(gi));
         assign lane_pad = flush_go && ((CW+1)'(gi) >= next_lane);
         assign data_next[gi*IW +: IW] = lane_wr  ? data_i.data :
                                         lane_pad ? '0 : data_reg[gi*IW +: IW];
         assign strb_next[gi*SW +: SW] = lane_wr ? data_i.strb :
                                         (lane_pad || out_hs) ? '0 : strb_reg[gi*SW +: SW];
      end
   endgenerate

   // The tile length is only sampled on the first word, so mid-tile edits are ignored.
   assign eff_len   = (word_cnt_reg != 8'd0) ? tile_len_reg :
                      (tile_beats_i == 8'd0) ? 8'd1 : tile_beats_i;
   assign tile_last = (word_cnt_reg == eff_len - 8'd1);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_reg    <= Fill;
         lane_cnt_reg <= '0;
         data_reg     <= '0;
         strb_reg     <= '0;
         word_cnt_reg <= 8'd0;
         tile_len_reg <= 8'd0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lane_cnt_reg <= lane_cnt_next;
         data_reg     <= data_next;
         strb_reg     <= strb_next;
         done_reg     <= out_hs && tile_last;
         if (out_hs) begin
            if (word_cnt_reg == 8'd0) begin
               tile_len_reg <= eff_len;
            end
            word_cnt_reg <= tile_last ? 8'd0 : word_cnt_reg + 8'd1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         Fill:    if (word_done) state_next = Drain;
         Drain:   if (data_o.ready) state_next = Fill;
         default: state_next = Fill;
      endcase
   end

   always_comb begin
      data_i.ready = fill;
      data_o.valid = !fill;
   end

   assign data_o.data = data_reg;
   assign data_o.strb = strb_reg;
   assign done_o      = done_reg;

endmodule

// File: tb/tb_ita_hwpe_bias_stream_packer.sv
// Directed vector bench for the bias stream packer: table of packing cases plus
// hand sequences for latency, tiles, backpressure, idle flush, reset and clear.
module tb_ita_hwpe_bias_stream_packer;

   localparam int IW = 32;
   localparam int OW = 768;
   localparam int R  = OW / IW;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       clear_i = 1'b0;
   logic       flush_i = 1'b0;
   logic [7:0] tile_beats_i = 8'd0;
   logic       done_o;

   hwpe_stream_intf_stream #(.DATA_WIDTH(IW)) in_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(OW)) out_if ();

   ita_hwpe_bias_stream_packer #(
      .INPUT_DATA_WIDTH (IW),
      .OUTPUT_DATA_WIDTH(OW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .flush_i     (flush_i),
      .tile_beats_i(tile_beats_i),
      .data_i      (in_if),
      .data_o      (out_if),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          nbeats;
      bit          flush_last;
      bit          flush_after;
      logic [31:0] base;
      int          exp_lanes;
   } vec_t;

   vec_t vecs [7];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] exp_data(input logic [31:0] base, input int n);
      logic [OW-1:0] d = '0;
      for (int k = 0; k < n; k++) d[k*IW +: IW] = base + 32'(k);
      return d;
   endfunction

   function automatic logic [OW/8-1:0] exp_strb(input int n);
      logic [OW/8-1:0] s = '0;
      for (int k = 0; k < n; k++) s[k*4 +: 4] = 4'hF;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends n back-to-back beats; optionally raises flush together with the last one.
   task automatic send_beats(input logic [31:0] base, input int n, input bit flush_last);
      for (int k = 0; k < n; k++) begin
         int t = 0;
         in_if.valid = 1'b1;
         in_if.data  = base + 32'(k);
         in_if.strb  = '1;
         flush_i     = flush_last && (k == n - 1);
         while (!in_if.ready && t < 40) begin
            tick();
            t++;
         end
         if (t == 40) chk("in_ready_timeout", OW'(in_if.ready), OW'(1));
         tick();
      end
      in_if.valid = 1'b0;
      flush_i     = 1'b0;
   endtask

   task automatic flush_pulse();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
   endtask

   initial begin
      vecs[0] = '{nbeats: 24, flush_last: 0, flush_after: 0, base: 32'h0000_0001, exp_lanes: 24};
      vecs[1] = '{nbeats: 5,  flush_last: 0, flush_after: 1, base: 32'hA000_0000, exp_lanes: 5};
      vecs[2] = '{nbeats: 24, flush_last: 1, flush_after: 0, base: 32'h1000_0100, exp_lanes: 24};
      vecs[3] = '{nbeats: 1,  flush_last: 0, flush_after: 1, base: 32'hDEAD_BEE0, exp_lanes: 1};
      vecs[4] = '{nbeats: 10, flush_last: 1, flush_after: 0, base: 32'h0000_5000, exp_lanes: 10};
      vecs[5] = '{nbeats: 23, flush_last: 0, flush_after: 1, base: 32'h7700_0000, exp_lanes: 23};
      vecs[6] = '{nbeats: 1,  flush_last: 1, flush_after: 0, base: 32'h0BAD_F00D, exp_lanes: 1};

      in_if.valid  = 1'b0;
      in_if.data   = '0;
      in_if.strb   = '0;
      out_if.ready = 1'b1;

      // Reset state, sampled while reset is still held.
      tick();
      tick();
      chk("rst_valid", OW'(out_if.valid), OW'(0));
      chk("rst_data", out_if.data, '0);
      chk("rst_strb", OW'(out_if.strb), '0);
      chk("rst_in_ready", OW'(in_if.ready), OW'(1));
      chk("rst_done", OW'(done_o), OW'(0));
      rst_ni = 1'b1;
      tick();

      // Table: tile length 0 means one word per tile, so every word pulses done.
      tile_beats_i = 8'd0;
      for (int i = 0; i < 7; i++) begin
         send_beats(vecs[i].base, vecs[i].nbeats, vecs[i].flush_last);
         if (vecs[i].flush_after) flush_pulse();
         chk($sformatf("v%0d_valid", i), OW'(out_if.valid), OW'(1));
         chk($sformatf("v%0d_data", i), out_if.data, exp_data(vecs[i].base, vecs[i].exp_lanes));
         chk($sformatf("v%0d_strb", i), OW'(out_if.strb), OW'(exp_strb(vecs[i].exp_lanes)));
         tick();
         chk($sformatf("v%0d_valid_low", i), OW'(out_if.valid), OW'(0));
         chk($sformatf("v%0d_in_ready", i), OW'(in_if.ready), OW'(1));
         chk($sformatf("v%0d_done", i), OW'(done_o), OW'(1));
         $display("vector %0d: %0d beats, %0d lanes packed, done=%0b", i, vecs[i].nbeats,
                  vecs[i].exp_lanes, done_o);
      end

      // Flush while idle at lane 0 must not produce a word.
      flush_pulse();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("idle_flush_valid_c%0d", c), OW'(out_if.valid), OW'(0));
         tick();
      end
      $display("idle flush: no word emitted");

      // Two-word tile; a mid-tile change of tile_beats_i is ignored.
      tile_beats_i = 8'd2;
      send_beats(32'h0002_0000, 24, 1'b0);
      chk("tile_w1_valid", OW'(out_if.valid), OW'(1));
      tick();
      chk("tile_w1_done", OW'(done_o), OW'(0));
      tile_beats_i = 8'd5;
      send_beats(32'h0003_0000, 24, 1'b0);
      chk("tile_w2_data", out_if.data, exp_data(32'h0003_0000, 24));
      tick();
      chk("tile_w2_done", OW'(done_o), OW'(1));
      tick();
      chk("tile_done_1cyc", OW'(done_o), OW'(0));
      tile_beats_i = 8'd1;
      send_beats(32'h0004_0000, 24, 1'b0);
      tick();
      chk("tile_restart_done", OW'(done_o), OW'(1));
      $display("tile: 2-word tile done, counter restarted");

      // Backpressure: output held for 10 cycles.
      out_if.ready = 1'b0;
      send_beats(32'h0005_0000, 24, 1'b0);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("bp_valid_c%0d", c), OW'(out_if.valid), OW'(1));
         chk($sformatf("bp_data_c%0d", c), out_if.data, exp_data(32'h0005_0000, 24));
         chk($sformatf("bp_strb_c%0d", c), OW'(out_if.strb), OW'(exp_strb(24)));
         chk($sformatf("bp_in_ready_c%0d", c), OW'(in_if.ready), OW'(0));
         tick();
      end
      out_if.ready = 1'b1;
      tick();
      chk("bp_hs_valid", OW'(out_if.valid), OW'(0));
      chk("bp_hs_in_ready", OW'(in_if.ready), OW'(1));
      $display("backpressure: word held 10 cycles then accepted");

      // Reset after 7 beats discards them.
      send_beats(32'h0006_0000, 7, 1'b0);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      chk("mid_rst_valid", OW'(out_if.valid), OW'(0));
      chk("mid_rst_done", OW'(done_o), OW'(0));
      send_beats(32'h0007_0000, 24, 1'b0);
      chk("post_rst_valid", OW'(out_if.valid), OW'(1));
      chk("post_rst_data", out_if.data, exp_data(32'h0007_0000, 24));
      tick();
      $display("reset mid-word: clean word afterwards");

      // Clear while a word waits in Drain drops it.
      out_if.ready = 1'b0;
      send_beats(32'h0008_0000, 24, 1'b0);
      chk("pre_clr_valid", OW'(out_if.valid), OW'(1));
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("clr_valid", OW'(out_if.valid), OW'(0));
      chk("clr_strb", OW'(out_if.strb), '0);
      chk("clr_done", OW'(done_o), OW'(0));
      out_if.ready = 1'b1;
      send_beats(32'h0009_0000, 24, 1'b0);
      chk("post_clr_data", out_if.data, exp_data(32'h0009_0000, 24));
      chk("post_clr_strb", OW'(out_if.strb), OW'(exp_strb(24)));
      tick();
      $display("clear in drain: word dropped, next word clean");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
